// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard with the
// request-to-send sequence, driving ps2_clk/ps2_data through open-drain pull-down enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [9:0]       sr;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             ack;

  logic clk_meta, clk_s, clk_s_prev;
  logic data_meta, data_s;
  logic fall;

  // NOTE: synchronisers reset to 1 (the idle bus level) so leaving reset never fakes a clock fall.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      clk_meta   <= 1'b1;
      clk_s      <= 1'b1;
      clk_s_prev <= 1'b1;
      data_meta  <= 1'b1;
      data_s     <= 1'b1;
      fall       <= 1'b0;
    end else begin
      clk_meta   <= ps2_clk;
      clk_s      <= clk_meta;
      clk_s_prev <= clk_s;
      data_meta  <= ps2_data;
      data_s     <= data_meta;
      fall       <= clk_s_prev & ~clk_s;
    end
  end

  assign rx_inhibit = tx_busy;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ack         <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_start) begin
            // Frame shifted out LSB first after the start bit: data, odd parity, stop.
            sr         <= {1'b1, ~^tx_data, tx_data};
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            ack        <= 1'b0;
            ps2_clk_oe <= 1'b1;
            tx_busy    <= 1'b1;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= S_START;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end

        S_START: begin
          ps2_clk_oe <= 1'b0;
          to_cnt     <= '0;
          state      <= S_SEND;
        end

        S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
          // A silent or stuck device must not hold the bus forever; this wins over any fall.
          if (to_cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            tx_busy     <= 1'b0;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (state == S_SEND) begin
              if (fall) begin
                ps2_data_oe <= ~sr[0];
                sr          <= {1'b0, sr[9:1]};
                bit_cnt     <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd9) state <= S_WAIT_ACK;
              end
            end else if (state == S_WAIT_ACK) begin
              if (fall) begin
                ack   <= ~data_s;
                state <= S_WAIT_IDLE;
              end
            end else if (clk_s && data_s) begin
              tx_done  <= ack;
              tx_error <= ~ack;
              tx_busy  <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_busy     <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device transmitter for the PS/2 keyboard port. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the keyboard using the PS/2 request-to-send sequence. The keyboard generates the clock; this block drives the lines through open-drain enables. It sits beside the PS/2 receiver on the same ps2_clk/ps2_data pins. It asserts rx_inhibit so the receiver ignores traffic while a host transmission is in progress.

Parameters:
INHIBIT_CYCLES, 5000, number of sys_clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum sys_clk cycles from clock release to line-idle after the ACK (15 ms at 50 MHz).

Ports:
sys_clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
tx_data  input  8  command byte; sampled on an accepted tx_start.
tx_start  input  1  one-cycle request; accepted only when tx_busy=0.
tx_busy  output  1  high from the cycle after acceptance until return to IDLE.
tx_done  output  1  one-cycle pulse: byte sent and device ACK received.
tx_error  output  1  one-cycle pulse: no ACK, or timeout.
rx_inhibit  output  1  equals tx_busy; the receiver must discard data while high.
ps2_clk  input  1  raw PS/2 clock pin level.
ps2_data  input  1  raw PS/2 data pin level.
ps2_clk_oe  output  1  1 = pull ps2_clk low; 0 = release.
ps2_data_oe  output  1  1 = pull ps2_data low; 0 = release.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset asserted mid-transfer releases both lines immediately.
- Synchronisation:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser, giving clk_s and data_s.
  - fall = clk_s_prev & ~clk_s, registered.
- Latches:
  - On acceptance, shift register sr[9:0] = {1'b1 stop, ~^tx_data odd parity, tx_data}.
  - The bit counter is cleared.
- State IDLE:
  - Both oe = 0.
  - tx_start=1 -> INHIBIT. ps2_clk_oe=1 and tx_busy=1 in the next cycle.
- State INHIBIT:
  - ps2_clk_oe=1; counts INHIBIT_CYCLES cycles.
  - -> START.
- State START (exactly 1 cycle):
  - ps2_clk_oe=1, ps2_data_oe=1 (start bit 0).
  - -> SEND.
  - Clears the timeout counter.
- State SEND:
  - ps2_clk_oe=0.
  - Each fall: ps2_data_oe <= ~sr[0]; sr shifts right; bit counter increments.
  - Falls 1-8 drive data bits LSB first; fall 9 drives parity; fall 10 drives stop (data_oe=0).
  - After fall 10 -> WAIT_ACK.
- State WAIT_ACK:
  - On fall 11, sample data_s. 0 = ACK flag set, 1 = NACK.
  - -> WAIT_IDLE.
- State WAIT_IDLE:
  - Waits until clk_s=1 and data_s=1 for 1 cycle.
  - Then pulses tx_done (ACK) or tx_error (NACK) and returns to IDLE.
  - tx_busy drops in the same cycle as the pulse.
- Timeout:
  - The counter runs in SEND, WAIT_ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces both oe=0, pulses tx_error and returns to IDLE.
  - Timeout takes priority over a simultaneous fall.
- tx_start while busy is ignored; tx_data changes while busy have no effect.
- tx_done and tx_error are never high together, and never for more than 1 cycle.
- Counter widths: INHIBIT counter is clog2(INHIBIT_CYCLES+1); timeout counter is clog2(TIMEOUT_CYCLES+1); bit counter is 4 bits.
- Glitches on ps2_clk shorter than 2 sys_clk cycles may be missed. Such glitches are not required to be filtered.

Test Plan:
(Bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=4000, and a device model clocking at a 200-cycle period.)
1. Byte 0xED, device ACKs -> ps2_clk_oe=1 for 20 cycles, then 1 START cycle with both oe=1. Sampled line bits: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. ACK low -> tx_done=1 for 1 cycle; tx_busy falls with it.
2. Byte 0x00 with no ACK (data stays high at fall 11) -> parity bit 1, stop 1, tx_error pulse once lines are idle, tx_done stays 0.
3. Device never clocks after START -> tx_error pulse exactly 4000 cycles after clock release; both oe=0; state IDLE.
4. tx_start pulsed again with tx_data=0xFF during the 0xED transfer -> transfer completes with 0xED bits; no second transfer starts.
5. Reset asserted after fall 5 -> ps2_clk_oe and ps2_data_oe go 0 asynchronously and all outputs read 0. A following tx_start of 0xF4 sends a complete, correct frame (parity bit 0).
6. Byte 0xFF, ACK -> parity bit 1, stop 1, tx_done pulse. rx_inhibit is high for the whole interval from acceptance to the done pulse.
